eth_tx_rr_arbiter: RTL and testbench

Packet-level round-robin arbiter that shares the single 64-bit AXI-Stream TX port of the 10G Ethernet MAC channel among `P_SRC_NUM` upstream sources. It sits in the MAC TX clock domain, between the per-source packet generators and the MAC `tx0_axis_*` input. It guarantees that packets are never interleaved, holds off new packets while the link is down, and truncates oversize frames.

---
 rtl/eth_tx_arb_pkg.sv | 14 +
 rtl/rr_pick.sv | 32 +++
 rtl/eth_tx_rr_arbiter.sv | 159 +++++++++++++++
 tb/tb_eth_tx_rr_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_tx_arb_pkg.sv
// Shared types and defaults for the Ethernet TX packet arbiter.
package eth_tx_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    localparam int P_MAX_BEATS_DEF = 1200;
    localparam int AXIS_DW         = 64;
    localparam int AXIS_KW         = AXIS_DW / 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: first request after i_last, wrapping.
// Zero latency; pure function of its inputs.
module rr_pick #(
    parameter int P_N  = 4,
    parameter int P_IW = $clog2(P_N)
) (
    input  logic [P_N-1:0]  i_req,
    input  logic [P_IW-1:0] i_last,
    output logic [P_N-1:0]  o_pick,
    output logic [P_IW-1:0] o_idx,
    output logic            o_any
);

    logic [P_IW-1:0] w_cand;

    always_comb begin
        o_pick = '0;
        o_idx  = '0;
        o_any  = 1'b0;
        w_cand = '0;
        // Offset 1 first, so the previous owner is considered last.
        for (int k = 1; k <= P_N; k++) begin
            w_cand = P_IW'((int'(i_last) + k) % P_N);
            if (!o_any && i_req[w_cand]) begin
                o_any          = 1'b1;
                o_idx          = w_cand;
                o_pick[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/eth_tx_rr_arbiter.sv
// Packet-level round-robin arbiter onto the MAC TX stream; 1-cycle grant, 0-cycle data path.
// Source ready mirrors MAC ready in XFER; oversize packets are cut and their tail drained.
module eth_tx_rr_arbiter
    import eth_tx_arb_pkg::*;
#(
    parameter int P_SRC_NUM   = 4,
    parameter int P_MAX_BEATS = P_MAX_BEATS_DEF
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_link_up,
    input  logic [P_SRC_NUM-1:0]         s_axis_tvalid,
    output logic [P_SRC_NUM-1:0]         s_axis_tready,
    input  logic [AXIS_DW*P_SRC_NUM-1:0] s_axis_tdata,
    input  logic [AXIS_KW*P_SRC_NUM-1:0] s_axis_tkeep,
    input  logic [P_SRC_NUM-1:0]         s_axis_tlast,
    input  logic [P_SRC_NUM-1:0]         s_axis_tuser,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic [AXIS_DW-1:0]           m_axis_tdata,
    output logic [AXIS_KW-1:0]           m_axis_tkeep,
    output logic                         m_axis_tlast,
    output logic                         m_axis_tuser,
    output logic [P_SRC_NUM-1:0]         o_grant,
    output logic [15:0]                  o_trunc_cnt
);

    localparam int LP_IW = $clog2(P_SRC_NUM);
    localparam int LP_CW = $clog2(P_MAX_BEATS + 1);
    localparam logic [LP_CW-1:0] LP_CNT_MAX   = LP_CW'(P_MAX_BEATS - 1);
    localparam logic [LP_IW-1:0] LP_LAST_INIT = LP_IW'(P_SRC_NUM - 1);

    arb_state_t           r_state;
    arb_state_t           w_state_nxt;
    logic [P_SRC_NUM-1:0] r_grant;
    logic [LP_IW-1:0]     r_gidx;
    logic [LP_IW-1:0]     r_last_owner;
    logic [LP_CW-1:0]     r_cnt;
    logic [15:0]          r_trunc_cnt;

    logic [P_SRC_NUM-1:0] w_req;
    logic [P_SRC_NUM-1:0] w_pick;
    logic [LP_IW-1:0]     w_pick_idx;
    logic                 w_pick_any;

    logic [AXIS_DW-1:0]   w_src_dat  [P_SRC_NUM];
    logic [AXIS_KW-1:0]   w_src_keep [P_SRC_NUM];
    logic                 w_g_vld;
    logic                 w_g_last;
    logic                 w_g_user;
    logic                 w_at_max;
    logic                 w_force;
    logic                 w_m_hs;
    logic                 w_end_xfer;
    logic                 w_end_drain;
    logic                 w_release;

    // A downed link only blocks new grants; packets in flight are unaffected.
    assign w_req = i_link_up ? s_axis_tvalid : '0;

    rr_pick #(
        .P_N  (P_SRC_NUM),
        .P_IW (LP_IW)
    ) u_rr_pick (
        .i_req  (w_req),
        .i_last (r_last_owner),
        .o_pick (w_pick),
        .o_idx  (w_pick_idx),
        .o_any  (w_pick_any)
    );

    always_comb begin
        for (int i = 0; i < P_SRC_NUM; i++) begin
            w_src_dat[i]  = s_axis_tdata[i*AXIS_DW +: AXIS_DW];
            w_src_keep[i] = s_axis_tkeep[i*AXIS_KW +: AXIS_KW];
        end
    end

    assign w_g_vld     = s_axis_tvalid[r_gidx];
    assign w_g_last    = s_axis_tlast[r_gidx];
    assign w_g_user    = s_axis_tuser[r_gidx];
    assign w_at_max    = (r_cnt == LP_CNT_MAX);
    assign w_force     = (r_state == XFER) && w_at_max && !w_g_last;
    assign w_m_hs      = (r_state == XFER) && w_g_vld && m_axis_tready;
    assign w_end_xfer  = w_m_hs && (w_g_last || w_at_max);
    assign w_end_drain = (r_state == DRAIN) && w_g_vld && w_g_last;
    assign w_release   = (w_end_xfer && w_g_last) || w_end_drain;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_pick_any)  w_state_nxt = XFER;
            XFER:    if (w_end_xfer)  w_state_nxt = w_g_last ? IDLE : DRAIN;
            DRAIN:   if (w_end_drain) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        m_axis_tvalid = 1'b0;
        s_axis_tready = '0;
        m_axis_tdata  = w_src_dat[r_gidx];
        m_axis_tkeep  = w_src_keep[r_gidx];
        m_axis_tlast  = w_g_last || w_force;
        m_axis_tuser  = w_g_user || w_force;
        case (r_state)
            XFER: begin
                m_axis_tvalid = w_g_vld;
                s_axis_tready = r_grant & {P_SRC_NUM{m_axis_tready}};
            end
            DRAIN: begin
                s_axis_tready = r_grant;
            end
            default: begin
                m_axis_tvalid = 1'b0;
                s_axis_tready = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_grant      <= '0;
            r_gidx       <= '0;
            r_last_owner <= LP_LAST_INIT;
            r_cnt        <= '0;
            r_trunc_cnt  <= '0;
        end else begin
            if ((r_state == IDLE) && w_pick_any) begin
                r_grant <= w_pick;
                r_gidx  <= w_pick_idx;
                r_cnt   <= '0;
            end
            // Counter holds at the cut point, so it can never wrap.
            if (w_m_hs && !w_end_xfer) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_release) begin
                r_grant      <= '0;
                r_last_owner <= r_gidx;
            end
            if (w_m_hs && w_force && (r_trunc_cnt != 16'hFFFF)) begin
                r_trunc_cnt <= r_trunc_cnt + 16'd1;
            end
        end
    end

    assign o_grant     = r_grant;
    assign o_trunc_cnt = r_trunc_cnt;

endmodule

// File: tb/tb_eth_tx_rr_arbiter.sv
// Bench for eth_tx_rr_arbiter: per-source packet queues and a packet-level reference model.
module tb_eth_tx_rr_arbiter;

    localparam int N    = 4;
    localparam int MAXB = 16;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        logic        u;
    } beat_t;

    logic            i_clk = 1'b0;
    logic            i_rst;
    logic            i_link_up;
    logic [N-1:0]    s_axis_tvalid;
    logic [N-1:0]    s_axis_tready;
    logic [64*N-1:0] s_axis_tdata;
    logic [8*N-1:0]  s_axis_tkeep;
    logic [N-1:0]    s_axis_tlast;
    logic [N-1:0]    s_axis_tuser;
    logic            m_axis_tvalid;
    logic            m_axis_tready;
    logic [63:0]     m_axis_tdata;
    logic [7:0]      m_axis_tkeep;
    logic            m_axis_tlast;
    logic            m_axis_tuser;
    logic [N-1:0]    o_grant;
    logic [15:0]     o_trunc_cnt;

    always #5 i_clk = ~i_clk;

    eth_tx_rr_arbiter #(
        .P_SRC_NUM   (N),
        .P_MAX_BEATS (MAXB)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_link_up     (i_link_up),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .o_grant       (o_grant),
        .o_trunc_cnt   (o_trunc_cnt)
    );

    int    n_cmp = 0;
    int    n_err = 0;
    beat_t srcq [N][$];
    beat_t exp_q[$];
    int    own = -1;
    int    nxt_own = -1;
    int    last_own = N - 1;
    int    drain_left = 0;
    int    exp_trunc = 0;
    int    n_mbeats = 0;
    int    mode = 0;
    logic [N-1:0] pop;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int o);
        logic [N-1:0] v;
        v = '0;
        if (o >= 0) v[o] = 1'b1;
        return v;
    endfunction

    task automatic add_pkt(input int s, input int len);
        beat_t bt;
        for (int b = 0; b < len; b++) begin
            bt.d = {8'(s), 8'(b), 16'($urandom), 32'($urandom)};
            bt.k = (b == len - 1) ? 8'($urandom_range(1, 255)) : 8'hFF;
            bt.l = (b == len - 1);
            bt.u = 1'($urandom);
            srcq[s].push_back(bt);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (srcq[i].size() > 0) begin
                s_axis_tvalid[i]          = 1'b1;
                s_axis_tdata[i*64 +: 64]  = srcq[i][0].d;
                s_axis_tkeep[i*8 +: 8]    = srcq[i][0].k;
                s_axis_tlast[i]           = srcq[i][0].l;
                s_axis_tuser[i]           = srcq[i][0].u;
            end else begin
                s_axis_tvalid[i]          = 1'b0;
                s_axis_tdata[i*64 +: 64]  = '0;
                s_axis_tkeep[i*8 +: 8]    = '0;
                s_axis_tlast[i]           = 1'b0;
                s_axis_tuser[i]           = 1'b0;
            end
        end
        case (mode)
            1:       m_axis_tready = ~m_axis_tready;
            2:       m_axis_tready = 1'($urandom);
            default: m_axis_tready = 1'b1;
        endcase
    endtask

    // Expected MAC view of the head packet of source s: cut at MAXB beats, cut beat flagged.
    task automatic start_pkt(input int s);
        int    len;
        beat_t bt;
        len = 0;
        while (!srcq[s][len].l) len++;
        len++;
        for (int j = 0; j < len && j < MAXB; j++) begin
            bt = srcq[s][j];
            if (len > MAXB && j == MAXB - 1) begin
                bt.l = 1'b1;
                bt.u = 1'b1;
            end
            exp_q.push_back(bt);
        end
        drain_left = (len > MAXB) ? len - MAXB : 0;
        if (len > MAXB) exp_trunc++;
    endtask

    task automatic cycle();
        @(negedge i_clk);
        pop     = '0;
        nxt_own = own;
        chk("grant", o_grant, onehot(own));
        if (own < 0) begin
            chk("idle_srdy", s_axis_tready, '0);
            chk("idle_mvld", m_axis_tvalid, 1'b0);
            if (i_link_up && (|s_axis_tvalid)) begin
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (last_own + k) % N;
                    if (nxt_own < 0 && s_axis_tvalid[c]) begin
                        nxt_own = c;
                        start_pkt(c);
                    end
                end
            end
        end else if (exp_q.size() > 0) begin
            chk("xfer_mvld", m_axis_tvalid, 1'b1);
            chk("xfer_srdy", s_axis_tready, onehot(own) & {N{m_axis_tready}});
            if (m_axis_tvalid && m_axis_tready) begin
                chk("beat", {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser}, exp_q.pop_front());
                n_mbeats++;
                pop[own] = 1'b1;
                if (exp_q.size() == 0 && drain_left == 0) begin
                    last_own = own;
                    nxt_own  = -1;
                end
            end
        end else begin
            chk("drain_mvld", m_axis_tvalid, 1'b0);
            chk("drain_srdy", s_axis_tready, onehot(own));
            if (s_axis_tvalid[own]) begin
                pop[own] = 1'b1;
                drain_left--;
                if (drain_left == 0) begin
                    last_own = own;
                    nxt_own  = -1;
                end
            end
        end
        @(posedge i_clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (pop[i]) void'(srcq[i].pop_front());
        end
        own = nxt_own;
        if (i_rst) begin
            own        = -1;
            last_own   = N - 1;
            drain_left = 0;
            exp_trunc  = 0;
            exp_q.delete();
            for (int i = 0; i < N; i++) srcq[i].delete();
        end
        drive();
    endtask

    function automatic bit pending();
        bit p;
        p = (own >= 0);
        for (int i = 0; i < N; i++) if (srcq[i].size() > 0) p = 1'b1;
        return p;
    endfunction

    task automatic run_idle();
        int t;
        t = 0;
        while (pending() && t < 3000) begin
            cycle();
            t++;
        end
        chk("idle_timeout", (t < 3000), 1'b1);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        i_rst         = 1'b1;
        i_link_up     = 1'b1;
        s_axis_tvalid = '0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = '0;
        s_axis_tuser  = '0;
        m_axis_tready = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        drive();

        // Reset state
        cycle();
        chk("rst_trunc", o_trunc_cnt, 16'd0);

        // Basic 4-beat packet from source 0
        add_pkt(0, 4);
        drive();
        run_idle();

        // Fairness: all sources request 2-beat packets continuously
        for (int r = 0; r < 3; r++)
            for (int s = 0; s < N; s++) add_pkt(s, 2);
        drive();
        run_idle();

        // Backpressure on an 8-beat packet
        mode = 1;
        add_pkt(2, 8);
        drive();
        run_idle();
        mode = 0;

        // Link gating and link loss mid-packet
        i_link_up = 1'b0;
        add_pkt(2, 3);
        drive();
        repeat (5) cycle();
        i_link_up = 1'b1;
        b0 = n_mbeats;
        for (int t = 0; t < 20 && n_mbeats == b0; t++) cycle();
        i_link_up = 1'b0;
        run_idle();
        add_pkt(3, 2);
        drive();
        repeat (4) cycle();
        i_link_up = 1'b1;
        run_idle();

        // Oversize: 20 beats cut to 16
        add_pkt(1, 20);
        drive();
        run_idle();
        chk("trunc_cnt_1", o_trunc_cnt, 16'(exp_trunc));

        // Randomized traffic with random MAC backpressure
        mode = 2;
        for (int r = 0; r < 6; r++) begin
            repeat (5) add_pkt($urandom_range(0, N - 1), $urandom_range(1, 20));
            drive();
            run_idle();
            chk("trunc_cnt_rand", o_trunc_cnt, 16'(exp_trunc));
        end
        mode = 0;

        // Reset on beat 3 of a 6-beat packet; source 0 must win afterwards
        add_pkt(0, 2);
        drive();
        run_idle();
        add_pkt(1, 6);
        drive();
        b0 = n_mbeats;
        for (int t = 0; t < 30 && (n_mbeats - b0) < 2; t++) cycle();
        i_rst = 1'b1;
        cycle();
        i_rst = 1'b0;
        cycle();
        chk("post_rst_trunc", o_trunc_cnt, 16'd0);
        add_pkt(1, 3);
        add_pkt(0, 3);
        drive();
        run_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
